// File: rtl/mult_pipe_pkg.sv
// Shared types for the RV32M multiply unit: ALU function codes, pipe sideband packet,
// and the operand-signedness decode used at issue.
package mult_pipe_pkg;

    localparam int unsigned PREG_NUMBER = 64;
    localparam int unsigned PKT_DEST_W  = $clog2(PREG_NUMBER);

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU
    } ALU_FUNC;

    typedef struct packed {
        logic                  valid;
        ALU_FUNC               func;
        logic [PKT_DEST_W-1:0] dest;
    } mult_pkt_t;

    // Returns {opa_signed, opb_signed}.
    function automatic logic [1:0] mult_signed(input ALU_FUNC func);
        case (func)
            ALU_MUL, ALU_MULH: return 2'b11;
            ALU_MULHSU:        return 2'b10;
            default:           return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Issue / completion bundle between the issue stage, CDB and the multiply unit.
interface mult_pipe_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PREG_W    = $clog2(mult_pipe_pkg::PREG_NUMBER),
    parameter int unsigned BUF_DEPTH = 8
);
    import mult_pipe_pkg::*;

    logic                           execute_en_i;
    logic [XLEN-1:0]                opa;
    logic [XLEN-1:0]                opb;
    ALU_FUNC                        func;
    logic [PREG_W-1:0]              dest_reg_i;
    logic                           complete_en_i;
    logic                           branch_recover_i;
    logic                           ready_o;
    logic                           done_o;
    logic                           regfile_wr_en_o;
    logic [PREG_W-1:0]              dest_reg_o;
    logic [XLEN-1:0]                result_o;
    logic [$clog2(BUF_DEPTH+1)-1:0] occupancy_o;

    modport slave (
        input  execute_en_i, opa, opb, func, dest_reg_i, complete_en_i, branch_recover_i,
        output ready_o, done_o, regfile_wr_en_o, dest_reg_o, result_o, occupancy_o
    );

    modport master (
        output execute_en_i, opa, opb, func, dest_reg_i, complete_en_i, branch_recover_i,
        input  ready_o, done_o, regfile_wr_en_o, dest_reg_o, result_o, occupancy_o
    );

endinterface

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: consumes CHUNK multiplier bits, accumulates the partial
// product and carries the op sideband alongside.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  mult_pkt_t        in_pkt,
    input  logic [WIDTH-1:0] in_prod,
    input  logic [WIDTH-1:0] in_mcand,
    input  logic [WIDTH-1:0] in_mplier,
    output mult_pkt_t        out_pkt,
    output logic [WIDTH-1:0] out_prod,
    output logic [WIDTH-1:0] out_mcand,
    output logic [WIDTH-1:0] out_mplier
);
    mult_pkt_t        pkt_q;
    logic [WIDTH-1:0] prod_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] partial;

    // Product is taken modulo 2^WIDTH, which is exact for the sign-extended operands.
    assign partial = in_mcand * WIDTH'(in_mplier[CHUNK-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            pkt_q       <= in_pkt;
            pkt_q.valid <= in_pkt.valid && !flush;
            prod_q      <= in_prod + partial;
            mcand_q     <= in_mcand << CHUNK;
            mplier_q    <= in_mplier >> CHUNK;
        end
    end

    assign out_pkt    = pkt_q;
    assign out_prod   = prod_q;
    assign out_mcand  = mcand_q;
    assign out_mplier = mplier_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32M multiply unit with credit-based issue and an in-order result buffer
// that drains on CDB grant and is cleared on branch recovery.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned PREG_W    = $clog2(PREG_NUMBER),
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    mult_pipe_if.slave bus
);
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CHUNK = PW / NUM_STAGE;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] dest;
        logic [XLEN-1:0]   result;
    } entry_t;

    logic            accept, push, pop, ready, done;
    logic            a_signed, b_signed;
    mult_pkt_t       pkt    [NUM_STAGE+1];
    logic [PW-1:0]   prod   [NUM_STAGE+1];
    logic [PW-1:0]   mcand  [NUM_STAGE+1];
    logic [PW-1:0]   mplier [NUM_STAGE+1];
    entry_t          wr_entry;
    entry_t          mem_q  [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d, credit_q, credit_d;

    // Credits cover in-flight ops too, so the buffer never overflows and the pipe never stalls.
    assign ready  = credit_q < CNT_W'(BUF_DEPTH);
    assign done   = fifo_cnt_q != '0;
    assign accept = bus.execute_en_i && ready && !bus.branch_recover_i;
    assign pop    = bus.complete_en_i && done && !bus.branch_recover_i;
    assign push   = pkt[NUM_STAGE].valid && !bus.branch_recover_i;

    assign {a_signed, b_signed} = mult_signed(bus.func);
    assign pkt[0]    = '{valid: accept, func: bus.func, dest: bus.dest_reg_i};
    assign prod[0]   = '0;
    assign mcand[0]  = {{XLEN{a_signed & bus.opa[XLEN-1]}}, bus.opa};
    assign mplier[0] = {{XLEN{b_signed & bus.opb[XLEN-1]}}, bus.opb};

    for (genvar s = 0; s < NUM_STAGE; s++) begin : g_stage
        mult_pipe_stage #(
            .WIDTH (PW),
            .CHUNK (CHUNK)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (bus.branch_recover_i),
            .in_pkt     (pkt[s]),
            .in_prod    (prod[s]),
            .in_mcand   (mcand[s]),
            .in_mplier  (mplier[s]),
            .out_pkt    (pkt[s+1]),
            .out_prod   (prod[s+1]),
            .out_mcand  (mcand[s+1]),
            .out_mplier (mplier[s+1])
        );
    end

    always_comb begin
        wr_entry.dest = pkt[NUM_STAGE].dest;
        case (pkt[NUM_STAGE].func)
            ALU_MUL:                      wr_entry.result = prod[NUM_STAGE][XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: wr_entry.result = prod[NUM_STAGE][PW-1:XLEN];
            default:                      wr_entry.result = XLEN'(32'hfacebeec);
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        credit_d   = credit_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
        if (bus.branch_recover_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            credit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            credit_q   <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            credit_q   <= credit_d;
            if (push) mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.ready_o         = ready;
    assign bus.done_o          = done;
    assign bus.regfile_wr_en_o = pop;
    assign bus.dest_reg_o      = mem_q[rd_ptr_q].dest;
    assign bus.result_o        = mem_q[rd_ptr_q].result;
    assign bus.occupancy_o     = credit_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of credits, latency and in-order retirement.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_STAGE = 4;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned BUF_DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mult_pipe_if #(.XLEN(XLEN), .PREG_W(PREG_W), .BUF_DEPTH(BUF_DEPTH)) bus ();

    mult_pipe #(
        .XLEN      (XLEN),
        .NUM_STAGE (NUM_STAGE),
        .PREG_W    (PREG_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          rem;
        logic [5:0]  dest;
        logic [31:0] res;
    } fly_t;

    typedef struct {
        logic [5:0]  dest;
        logic [31:0] res;
    } ent_t;

    fly_t pipe_q[$];
    ent_t fifo_q[$];
    int   credits = 0;
    logic exp_done, m_acc, m_pop;
    fly_t fly;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input ALU_FUNC f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            default:    return 32'hfacebeec;
        endcase
    endfunction

    // Model: check outputs mid-cycle, then advance as the coming rising edge will.
    always @(negedge clk) begin
        if (!reset) begin
            pipe_q.delete();
            fifo_q.delete();
            credits = 0;
            chk("rst ready", bus.ready_o, 1);
            chk("rst done", bus.done_o, 0);
            chk("rst occupancy", bus.occupancy_o, 0);
            chk("rst wr_en", bus.regfile_wr_en_o, 0);
            chk("rst result", bus.result_o, 0);
            chk("rst dest", bus.dest_reg_o, 0);
        end else begin
            exp_done = fifo_q.size() != 0;
            m_acc    = bus.execute_en_i && (credits < BUF_DEPTH) && !bus.branch_recover_i;
            m_pop    = bus.complete_en_i && exp_done && !bus.branch_recover_i;
            chk("ready", bus.ready_o, credits < BUF_DEPTH);
            chk("done", bus.done_o, exp_done);
            chk("occupancy", bus.occupancy_o, credits);
            chk("wr_en", bus.regfile_wr_en_o, m_pop);
            if (exp_done) begin
                chk("head result", bus.result_o, fifo_q[0].res);
                chk("head dest", bus.dest_reg_o, fifo_q[0].dest);
            end
            if (bus.branch_recover_i) begin
                pipe_q.delete();
                fifo_q.delete();
                credits = 0;
            end else begin
                if (m_pop) begin
                    void'(fifo_q.pop_front());
                    credits--;
                end
                foreach (pipe_q[i]) pipe_q[i].rem--;
                while (pipe_q.size() > 0 && pipe_q[0].rem == 0) begin
                    fly = pipe_q.pop_front();
                    fifo_q.push_back('{dest: fly.dest, res: fly.res});
                end
                if (m_acc) begin
                    pipe_q.push_back('{rem: NUM_STAGE, dest: bus.dest_reg_i,
                                       res: ref_result(bus.func, bus.opa, bus.opb)});
                    credits++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input ALU_FUNC f, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] d);
        bus.execute_en_i = en;
        bus.func         = f;
        bus.opa          = a;
        bus.opb          = b;
        bus.dest_reg_i   = d;
    endtask

    task automatic run_single(input string name, input ALU_FUNC f, input logic [31:0] a,
                              input logic [31:0] b, input logic [5:0] d,
                              input logic [31:0] exp);
        int n;
        tick();
        drive(1'b1, f, a, b, d);
        tick();
        bus.execute_en_i = 1'b0;
        n = 1;
        while (!bus.done_o && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'd5);
        chk({name, " result"}, bus.result_o, exp);
        chk({name, " dest"}, bus.dest_reg_o, d);
        bus.complete_en_i = 1'b1;
        tick();
        bus.complete_en_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hffffffff;
            2:       return 32'h80000000;
            3:       return 32'h7fffffff;
            default: return $urandom;
        endcase
    endfunction

    ALU_FUNC funcs [5] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_ADD};

    initial begin
        int seen;
        drive(1'b0, ALU_MUL, 32'h0, 32'h0, 6'h0);
        bus.complete_en_i    = 1'b0;
        bus.branch_recover_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("post-reset ready", bus.ready_o, 1);
        chk("post-reset occupancy", bus.occupancy_o, 0);

        run_single("mul", ALU_MUL, 32'hffffffff, 32'h2, 6'd1, 32'hfffffffe);
        run_single("mulh", ALU_MULH, 32'hffffffff, 32'h2, 6'd2, 32'hffffffff);
        run_single("mulhu", ALU_MULHU, 32'hffffffff, 32'h2, 6'd3, 32'h00000001);
        run_single("mulhsu", ALU_MULHSU, 32'hffffffff, 32'h2, 6'd4, 32'hffffffff);

        // Eight back-to-back MULs fill every credit.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ALU_MUL, 32'(i), 32'd3, 6'(i));
            tick();
        end
        bus.execute_en_i = 1'b0;
        chk("full ready", bus.ready_o, 0);
        chk("full occupancy", bus.occupancy_o, 8);
        repeat (5) tick();
        bus.complete_en_i = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("drain wr_en", bus.regfile_wr_en_o, 1);
            chk("drain result", bus.result_o, 32'(3 * i));
            chk("drain dest", bus.dest_reg_o, 6'(i));
            tick();
        end
        bus.complete_en_i = 1'b0;
        chk("drained occupancy", bus.occupancy_o, 0);

        // Pop while full: the same-cycle issue must be refused.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ALU_MULHU, 32'hffffffff, 32'(i + 1), 6'(i + 8));
            tick();
        end
        bus.execute_en_i = 1'b0;
        repeat (5) tick();
        drive(1'b1, ALU_MUL, 32'd9, 32'd9, 6'd63);
        bus.complete_en_i = 1'b1;
        #1;
        chk("full pop ready", bus.ready_o, 0);
        chk("full pop wr_en", bus.regfile_wr_en_o, 1);
        tick();
        bus.execute_en_i = 1'b0;
        chk("after pop ready", bus.ready_o, 1);
        chk("after pop occupancy", bus.occupancy_o, 7);
        repeat (7) tick();
        bus.complete_en_i = 1'b0;
        chk("emptied occupancy", bus.occupancy_o, 0);

        // Two buffered, three in flight, then recover with issue and complete asserted.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ALU_MUL, 32'(i + 10), 32'd7, 6'(i + 20));
            tick();
        end
        bus.execute_en_i = 1'b0;
        tick();
        chk("pre-flush occupancy", bus.occupancy_o, 5);
        chk("pre-flush done", bus.done_o, 1);
        drive(1'b1, ALU_MUL, 32'd1, 32'd1, 6'd30);
        bus.complete_en_i    = 1'b1;
        bus.branch_recover_i = 1'b1;
        #1;
        chk("flush wr_en", bus.regfile_wr_en_o, 0);
        tick();
        bus.execute_en_i     = 1'b0;
        bus.complete_en_i    = 1'b0;
        bus.branch_recover_i = 1'b0;
        chk("post-flush occupancy", bus.occupancy_o, 0);
        chk("post-flush done", bus.done_o, 0);
        chk("post-flush ready", bus.ready_o, 1);
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.done_o) seen++;
        end
        chk("no done after flush", 64'(seen), 64'd0);

        // Asynchronous reset with ops in flight and stale head values present.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ALU_MUL, 32'd123, 32'd456, 6'(i + 40));
            tick();
        end
        bus.execute_en_i = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("async ready", bus.ready_o, 1);
        chk("async done", bus.done_o, 0);
        chk("async occupancy", bus.occupancy_o, 0);
        chk("async result", bus.result_o, 0);
        chk("async dest", bus.dest_reg_o, 0);
        tick();
        tick();
        reset = 1'b1;
        run_single("mul 7x6", ALU_MUL, 32'd7, 32'd6, 6'd5, 32'd42);

        // Non-multiply func between two MULs.
        drive(1'b1, ALU_MUL, 32'd5, 32'd5, 6'd1);
        tick();
        drive(1'b1, ALU_ADD, 32'd3, 32'd4, 6'd2);
        tick();
        drive(1'b1, ALU_MULHU, 32'hffffffff, 32'hffffffff, 6'd3);
        tick();
        bus.execute_en_i = 1'b0;
        repeat (5) tick();
        bus.complete_en_i = 1'b1;
        chk("neighbour mul", bus.result_o, 32'd25);
        tick();
        chk("add result", bus.result_o, 32'hfacebeec);
        tick();
        chk("neighbour mulhu", bus.result_o, 32'hfffffffe);
        tick();
        bus.complete_en_i = 1'b0;

        // Random traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7, funcs[$urandom_range(0, 4)], pick_op(), pick_op(),
                  6'($urandom));
            bus.complete_en_i    = $urandom_range(0, 1) == 1;
            bus.branch_recover_i = $urandom_range(0, 99) < 2;
            tick();
        end
        bus.execute_en_i     = 1'b0;
        bus.branch_recover_i = 1'b0;
        bus.complete_en_i    = 1'b1;
        repeat (20) tick();
        bus.complete_en_i = 1'b0;
        chk("final occupancy", bus.occupancy_o, 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
